// File: rtl/sram_4096x7_ctrl_pkg.sv
// Shared constants and FSM state type for the 4096x7 SRAM controller.
package sram_4096x7_ctrl_pkg;

    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 7;
    localparam logic [DATA_W-1:0] INIT_VAL = 7'd0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset init sweep: walks every macro address once, then parks in RUN.
module sram_init_seq
    import sram_4096x7_ctrl_pkg::*;
#(
    parameter int DEPTH  = sram_4096x7_ctrl_pkg::DEPTH,
    parameter int ADDR_W = sram_4096x7_ctrl_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_active,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_done;

    // The counter stops at the last address instead of wrapping, so the
    // macro is never re-initialised once RUN has been reached.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= RUN;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign o_addr   = r_cnt;
    assign o_active = (r_state == INIT);
    assign o_done   = r_done;

endmodule

// File: rtl/sram_4096x7_ctrl.sv
// Controller for a single-port 4096x7 SRAM macro: init sweep, write-priority
// request arbitration, and a held read response.
module sram_4096x7_ctrl
    import sram_4096x7_ctrl_pkg::*;
#(
    parameter int DEPTH  = sram_4096x7_ctrl_pkg::DEPTH,
    parameter int ADDR_W = sram_4096x7_ctrl_pkg::ADDR_W,
    parameter int DATA_W = sram_4096x7_ctrl_pkg::DATA_W,
    parameter logic [DATA_W-1:0] INIT_VAL = sram_4096x7_ctrl_pkg::INIT_VAL
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_w_req_valid,
    output logic              io_w_req_ready,
    input  logic [ADDR_W-1:0] io_w_req_bits_setIdx,
    input  logic [DATA_W-1:0] io_w_req_bits_data,
    input  logic              io_r_req_valid,
    output logic              io_r_req_ready,
    input  logic [ADDR_W-1:0] io_r_req_bits_setIdx,
    output logic              io_r_resp_valid,
    output logic [DATA_W-1:0] io_r_resp_data,
    output logic              io_init_done,
    output logic [ADDR_W-1:0] sram_RW0_addr,
    output logic              sram_RW0_en,
    output logic              sram_RW0_wmode,
    output logic [DATA_W-1:0] sram_RW0_wdata,
    input  logic [DATA_W-1:0] sram_RW0_rdata
);

    logic [ADDR_W-1:0] w_seq_addr;
    logic              w_seq_active;
    logic              w_seq_done;
    logic              w_run;
    logic              w_sweep;
    logic              w_wr_fire;
    logic              w_rd_fire;

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_hold_p1;

    sram_init_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .i_clk    (clock),
        .i_rst    (reset),
        .o_addr   (w_seq_addr),
        .o_active (w_seq_active),
        .o_done   (w_seq_done)
    );

    // Reset masks everything combinationally so the macro stays idle and the
    // handshake is closed for every cycle in which reset is high.
    assign w_run   = w_seq_done & ~reset;
    assign w_sweep = w_seq_active & ~reset;

    assign io_init_done   = w_run;
    assign io_w_req_ready = w_run;
    assign io_r_req_ready = w_run & ~io_w_req_valid;

    assign w_wr_fire = io_w_req_valid & io_w_req_ready;
    assign w_rd_fire = io_r_req_valid & io_r_req_ready;

    always_comb begin
        sram_RW0_en    = 1'b0;
        sram_RW0_wmode = 1'b0;
        sram_RW0_addr  = '0;
        sram_RW0_wdata = '0;
        if (w_sweep) begin
            sram_RW0_en    = 1'b1;
            sram_RW0_wmode = 1'b1;
            sram_RW0_addr  = w_seq_addr;
            sram_RW0_wdata = INIT_VAL;
        end else if (w_wr_fire) begin
            sram_RW0_en    = 1'b1;
            sram_RW0_wmode = 1'b1;
            sram_RW0_addr  = io_w_req_bits_setIdx;
            sram_RW0_wdata = io_w_req_bits_data;
        end else if (w_rd_fire) begin
            sram_RW0_en    = 1'b1;
            sram_RW0_wmode = 1'b0;
            sram_RW0_addr  = io_r_req_bits_setIdx;
        end
    end

    // Stage p1: macro read data arrives; flag it and capture it for holding.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_hold_p1 <= '0;
        end else begin
            r_vld_p1 <= w_rd_fire;
            if (r_vld_p1) begin
                r_hold_p1 <= sram_RW0_rdata;
            end
        end
    end

    assign io_r_resp_valid = r_vld_p1 & ~reset;
    assign io_r_resp_data  = reset    ? '0 :
                             r_vld_p1 ? sram_RW0_rdata : r_hold_p1;

endmodule

// File: tb/tb_sram_4096x7_ctrl.sv
// Self-checking bench for sram_4096x7_ctrl with a behavioural macro and reference memory.
module tb_sram_4096x7_ctrl;

    logic        clock;
    logic        reset;
    logic        io_w_req_valid;
    logic        io_w_req_ready;
    logic [11:0] io_w_req_bits_setIdx;
    logic [6:0]  io_w_req_bits_data;
    logic        io_r_req_valid;
    logic        io_r_req_ready;
    logic [11:0] io_r_req_bits_setIdx;
    logic        io_r_resp_valid;
    logic [6:0]  io_r_resp_data;
    logic        io_init_done;
    logic [11:0] sram_RW0_addr;
    logic        sram_RW0_en;
    logic        sram_RW0_wmode;
    logic [6:0]  sram_RW0_wdata;
    logic [6:0]  sram_RW0_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] macro_mem [4096];
    logic [6:0] ref_mem   [4096];
    logic [6:0] m_hold;

    sram_4096x7_ctrl dut (
        .clock                (clock),
        .reset                (reset),
        .io_w_req_valid       (io_w_req_valid),
        .io_w_req_ready       (io_w_req_ready),
        .io_w_req_bits_setIdx (io_w_req_bits_setIdx),
        .io_w_req_bits_data   (io_w_req_bits_data),
        .io_r_req_valid       (io_r_req_valid),
        .io_r_req_ready       (io_r_req_ready),
        .io_r_req_bits_setIdx (io_r_req_bits_setIdx),
        .io_r_resp_valid      (io_r_resp_valid),
        .io_r_resp_data       (io_r_resp_data),
        .io_init_done         (io_init_done),
        .sram_RW0_addr        (sram_RW0_addr),
        .sram_RW0_en          (sram_RW0_en),
        .sram_RW0_wmode       (sram_RW0_wmode),
        .sram_RW0_wdata       (sram_RW0_wdata),
        .sram_RW0_rdata       (sram_RW0_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural single-port macro, 1-cycle read latency; starts with garbage.
    initial begin
        for (int i = 0; i < 4096; i++) macro_mem[i] = 7'($urandom);
    end

    always @(posedge clock) begin
        if (sram_RW0_en) begin
            if (sram_RW0_wmode) macro_mem[sram_RW0_addr] <= sram_RW0_wdata;
            else                sram_RW0_rdata <= macro_mem[sram_RW0_addr];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        io_w_req_valid       = 1'b0;
        io_w_req_bits_setIdx = '0;
        io_w_req_bits_data   = '0;
        io_r_req_valid       = 1'b0;
        io_r_req_bits_setIdx = '0;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        @(negedge clock);
        obs = {io_init_done, io_w_req_ready, io_r_req_ready, io_r_resp_valid,
               sram_RW0_en, 2'b00};
        n_checks++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, want 0000000", obs);
        end
        n_checks++;
        if (io_r_resp_data !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h, want 00", io_r_resp_data);
        end
        tick();
        reset = 1'b0;
    endtask

    // Runs from the first cycle with reset low; requests must be ignored.
    task automatic test_init_sweep();
        logic [22:0] obs, exp;
        for (int i = 0; i < 4096; i++) begin
            io_w_req_valid       = 1'($urandom);
            io_w_req_bits_setIdx = 12'($urandom);
            io_w_req_bits_data   = 7'($urandom);
            io_r_req_valid       = 1'($urandom);
            io_r_req_bits_setIdx = 12'($urandom);
            @(negedge clock);
            obs = {io_init_done, io_w_req_ready, io_r_req_ready, sram_RW0_en,
                   sram_RW0_wmode, sram_RW0_addr, sram_RW0_wdata};
            exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'(i), 7'd0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL sweep_cycle_%0d: got %h, want %h", i, obs, exp);
            end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4096; i++) ref_mem[i] = 7'd0;
        @(negedge clock);
        obs = {io_init_done, io_w_req_ready, io_r_req_ready, sram_RW0_en,
               sram_RW0_wmode, sram_RW0_addr, sram_RW0_wdata};
        exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 7'd0};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL sweep_done: got %h, want %h", obs, exp);
        end
        tick();
    endtask

    task automatic test_write_read();
        io_w_req_valid = 1'b1; io_w_req_bits_setIdx = 12'h123; io_w_req_bits_data = 7'h55;
        @(negedge clock);
        n_checks++;
        if ({io_w_req_ready, io_r_req_ready, sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, sram_RW0_wdata}
            !== {1'b1, 1'b0, 1'b1, 1'b1, 12'h123, 7'h55}) begin
            n_fail++;
            $display("FAIL wr_macro: got en=%b wm=%b a=%h d=%h rdy=%b%b, want 1 1 123 55 10",
                     sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, sram_RW0_wdata,
                     io_w_req_ready, io_r_req_ready);
        end
        ref_mem[12'h123] = 7'h55;
        tick();
        idle_inputs();
        io_r_req_valid = 1'b1; io_r_req_bits_setIdx = 12'h123;
        @(negedge clock);
        n_checks++;
        if ({io_r_req_ready, sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, sram_RW0_wdata}
            !== {1'b1, 1'b1, 1'b0, 12'h123, 7'h00}) begin
            n_fail++;
            $display("FAIL rd_macro: got rdy=%b en=%b wm=%b a=%h d=%h, want 1 1 0 123 00",
                     io_r_req_ready, sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, sram_RW0_wdata);
        end
        tick();
        idle_inputs();
        @(negedge clock);
        n_checks++;
        if ({io_r_resp_valid, io_r_resp_data} !== {1'b1, 7'h55}) begin
            n_fail++;
            $display("FAIL rd_resp: got v=%b d=%h, want 1 55", io_r_resp_valid, io_r_resp_data);
        end
        m_hold = 7'h55;
        tick();
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                io_w_req_valid = 1'b1; io_w_req_bits_setIdx = 12'h124; io_w_req_bits_data = 7'h2A;
                ref_mem[12'h124] = 7'h2A;
            end else begin
                idle_inputs();
            end
            @(negedge clock);
            n_checks++;
            if ({io_r_resp_valid, io_r_resp_data} !== {1'b0, 7'h55}) begin
                n_fail++;
                $display("FAIL hold_idle_%0d: got v=%b d=%h, want 0 55", c, io_r_resp_valid, io_r_resp_data);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_collision();
        io_w_req_valid = 1'b1; io_w_req_bits_setIdx = 12'h456; io_w_req_bits_data = 7'h3C;
        io_r_req_valid = 1'b1; io_r_req_bits_setIdx = 12'h456;
        @(negedge clock);
        n_checks++;
        if ({io_w_req_ready, io_r_req_ready, sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, sram_RW0_wdata}
            !== {1'b1, 1'b0, 1'b1, 1'b1, 12'h456, 7'h3C}) begin
            n_fail++;
            $display("FAIL coll_priority: got rdy=%b%b en=%b wm=%b a=%h d=%h, want 10 1 1 456 3c",
                     io_w_req_ready, io_r_req_ready, sram_RW0_en, sram_RW0_wmode,
                     sram_RW0_addr, sram_RW0_wdata);
        end
        ref_mem[12'h456] = 7'h3C;
        tick();
        io_w_req_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({io_r_req_ready, sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, io_r_resp_valid}
            !== {1'b1, 1'b1, 1'b0, 12'h456, 1'b0}) begin
            n_fail++;
            $display("FAIL coll_retry: got rdy=%b en=%b wm=%b a=%h rv=%b, want 1 1 0 456 0",
                     io_r_req_ready, sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, io_r_resp_valid);
        end
        tick();
        idle_inputs();
        @(negedge clock);
        n_checks++;
        if ({io_r_resp_valid, io_r_resp_data} !== {1'b1, 7'h3C}) begin
            n_fail++;
            $display("FAIL coll_resp: got v=%b d=%h, want 1 3c", io_r_resp_valid, io_r_resp_data);
        end
        m_hold = 7'h3C;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [11:0] addrs [3];
        logic [6:0]  datas [3];
        addrs[0] = 12'hFFF; addrs[1] = 12'h000; addrs[2] = 12'h800;
        datas[0] = 7'h01;   datas[1] = 7'h02;   datas[2] = 7'h03;
        for (int k = 0; k < 3; k++) begin
            io_w_req_valid = 1'b1; io_w_req_bits_setIdx = addrs[k]; io_w_req_bits_data = datas[k];
            ref_mem[addrs[k]] = datas[k];
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                io_r_req_valid = 1'b1; io_r_req_bits_setIdx = addrs[k];
            end else begin
                io_r_req_valid = 1'b0;
            end
            @(negedge clock);
            if (k < 3) begin
                n_checks++;
                if ({sram_RW0_en, sram_RW0_wmode, sram_RW0_addr} !== {1'b1, 1'b0, addrs[k]}) begin
                    n_fail++;
                    $display("FAIL b2b_req_%0d: got en=%b wm=%b a=%h, want 1 0 %h",
                             k, sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, addrs[k]);
                end
            end
            n_checks++;
            if (k == 0) begin
                if (io_r_resp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_resp_0: got v=%b, want 0", io_r_resp_valid);
                end
            end else if (k < 4) begin
                if ({io_r_resp_valid, io_r_resp_data} !== {1'b1, datas[k-1]}) begin
                    n_fail++;
                    $display("FAIL b2b_resp_%0d: got v=%b d=%h, want 1 %h",
                             k, io_r_resp_valid, io_r_resp_data, datas[k-1]);
                end
            end else begin
                if ({io_r_resp_valid, io_r_resp_data} !== {1'b0, 7'h03}) begin
                    n_fail++;
                    $display("FAIL b2b_hold: got v=%b d=%h, want 0 03", io_r_resp_valid, io_r_resp_data);
                end
            end
            tick();
        end
        m_hold = 7'h03;
    endtask

    // Random traffic against a reference memory; addresses confined to 0x010..0x01F.
    task automatic test_random();
        logic        wv, rv, pend;
        logic [11:0] wa, ra;
        logic [6:0]  wd, pend_d, hold;
        logic [22:0] obs, exp;
        pend = 1'b0; pend_d = '0; hold = m_hold;
        for (int c = 0; c < 400; c++) begin
            wv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            wa = 12'h010 + 12'($urandom_range(0, 15));
            ra = 12'h010 + 12'($urandom_range(0, 15));
            wd = 7'($urandom);
            io_w_req_valid = wv; io_w_req_bits_setIdx = wa; io_w_req_bits_data = wd;
            io_r_req_valid = rv; io_r_req_bits_setIdx = ra;
            @(negedge clock);
            if (wv)      exp = {1'b1, 1'b0, 1'b1, 1'b1, wa, wd};
            else if (rv) exp = {1'b1, 1'b1, 1'b1, 1'b0, ra, 7'd0};
            else         exp = {1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 7'd0};
            obs = {io_w_req_ready, io_r_req_ready, sram_RW0_en, sram_RW0_wmode,
                   sram_RW0_addr, sram_RW0_wdata};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL rand_macro_%0d: got %h, want %h", c, obs, exp);
            end
            n_checks++;
            if ({io_r_resp_valid, io_r_resp_data} !== {pend, (pend ? pend_d : hold)}) begin
                n_fail++;
                $display("FAIL rand_resp_%0d: got v=%b d=%h, want %b %h",
                         c, io_r_resp_valid, io_r_resp_data, pend, (pend ? pend_d : hold));
            end
            if (pend) hold = pend_d;
            if (rv && !wv) begin
                pend = 1'b1; pend_d = ref_mem[ra];
            end else begin
                pend = 1'b0;
            end
            if (wv) ref_mem[wa] = wd;
            tick();
        end
        idle_inputs();
        @(negedge clock);
        n_checks++;
        if ({io_r_resp_valid, io_r_resp_data} !== {pend, (pend ? pend_d : hold)}) begin
            n_fail++;
            $display("FAIL rand_resp_tail: got v=%b d=%h, want %b %h",
                     io_r_resp_valid, io_r_resp_data, pend, (pend ? pend_d : hold));
        end
        if (pend) hold = pend_d;
        m_hold = hold;
        tick();
    endtask

    task automatic test_reset_run();
        io_r_req_valid = 1'b1; io_r_req_bits_setIdx = 12'hFFF;
        @(negedge clock);
        n_checks++;
        if ({sram_RW0_en, sram_RW0_wmode} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_run_read: got en=%b wm=%b, want 1 0", sram_RW0_en, sram_RW0_wmode);
        end
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        @(negedge clock);
        n_checks++;
        if ({io_r_resp_valid, io_r_resp_data, sram_RW0_en, io_init_done, io_w_req_ready, io_r_req_ready}
            !== 12'd0) begin
            n_fail++;
            $display("FAIL rst_run_flush: got v=%b d=%h en=%b done=%b rdy=%b%b, want all 0",
                     io_r_resp_valid, io_r_resp_data, sram_RW0_en, io_init_done,
                     io_w_req_ready, io_r_req_ready);
        end
        tick();
        reset = 1'b0;
    endtask

    // Entered with reset just released; reset is pulsed when the sweep reaches 2000.
    task automatic test_reset_mid_sweep();
        for (int c = 0; c < 2000; c++) tick();
        @(negedge clock);
        n_checks++;
        if ({sram_RW0_en, sram_RW0_addr} !== {1'b1, 12'd2000}) begin
            n_fail++;
            $display("FAIL mid_pre: got en=%b a=%0d, want 1 2000", sram_RW0_en, sram_RW0_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, io_init_done} !== {1'b1, 1'b1, 12'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_restart: got en=%b wm=%b a=%0d done=%b, want 1 1 0 0",
                     sram_RW0_en, sram_RW0_wmode, sram_RW0_addr, io_init_done);
        end
        for (int c = 0; c < 4095; c++) tick();
        @(negedge clock);
        n_checks++;
        if ({io_init_done, sram_RW0_en, sram_RW0_addr} !== {1'b0, 1'b1, 12'd4095}) begin
            n_fail++;
            $display("FAIL mid_last: got done=%b en=%b a=%0d, want 0 1 4095",
                     io_init_done, sram_RW0_en, sram_RW0_addr);
        end
        tick();
        @(negedge clock);
        n_checks++;
        if ({io_init_done, sram_RW0_en} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_done: got done=%b en=%b, want 1 0", io_init_done, sram_RW0_en);
        end
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        m_hold = 7'd0;
        idle_inputs();
        test_reset();
        test_init_sweep();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_run();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_4096x7_ctrl.md
SRAM_4096X7_CTRL -- requirements
Module: sram_4096x7_ctrl

Interface
REQ-001 Parameters SHALL be: DEPTH 4096 (entry count); ADDR_W 12 (address width); DATA_W 7 (data width); INIT_VAL 7'd0 (value written to every entry by the init sweep).
REQ-002 Ports SHALL be, in this order:
- clock in 1: sole clock.
- reset in 1: synchronous, active-high.
- io_w_req_valid in 1: write request.
- io_w_req_ready out 1: write accepted when valid and ready.
- io_w_req_bits_setIdx in ADDR_W: write address.
- io_w_req_bits_data in DATA_W: write data.
- io_r_req_valid in 1: read request.
- io_r_req_ready out 1: read accepted when valid and ready.
- io_r_req_bits_setIdx in ADDR_W: read address.
- io_r_resp_valid out 1: read data is fresh this cycle.
- io_r_resp_data out DATA_W: read data, held between reads.
- io_init_done out 1: init sweep complete.
- sram_RW0_addr out ADDR_W: macro address.
- sram_RW0_en out 1: macro enable.
- sram_RW0_wmode out 1: macro write mode (1 = write).
- sram_RW0_wdata out DATA_W: macro write data.
- sram_RW0_rdata in DATA_W: macro read data, valid the cycle after a macro read.

Function
REQ-003 The block SHALL drive a single-port synchronous SRAM macro that shares clock and has 1-cycle read latency.
REQ-004 The FSM SHALL have two states: INIT (entered on reset) and RUN; INIT->RUN occurs after the write to address DEPTH-1; RUN is left only by reset.
REQ-005 In INIT the block SHALL issue one macro write per cycle: en=1, wmode=1, wdata=INIT_VAL, addr = sweep counter running 0,1,...,4095.
REQ-006 The init sweep SHALL take exactly 4096 cycles after reset deasserts; io_init_done SHALL rise on the first RUN cycle (cycle 4096 after reset release).
REQ-007 The sweep counter SHALL NOT wrap to 0 and rewrite; 4095 SHALL be its terminal value.
REQ-008 In INIT, io_w_req_ready and io_r_req_ready SHALL be 0, and external requests SHALL be ignored.
REQ-009 In RUN, io_w_req_ready SHALL be 1.
REQ-010 In RUN, io_r_req_ready SHALL equal !io_w_req_valid, combinationally: write has priority and a read is refused in any cycle with a write request.
REQ-011 On write fire the block SHALL drive en=1, wmode=1, addr=w setIdx, wdata=w data in the same cycle.
REQ-012 On read fire the block SHALL drive en=1, wmode=0, addr=r setIdx in the same cycle.
REQ-013 With no fire in RUN, the block SHALL drive en=0; addr, wmode and wdata are don't-care but SHALL be driven to 0.
REQ-014 io_r_resp_valid SHALL be 1 exactly in the cycle after a read fire, otherwise 0.
REQ-015 When io_r_resp_valid=1, io_r_resp_data SHALL equal sram_RW0_rdata, and a hold register SHALL capture that value.
REQ-016 When io_r_resp_valid=0, io_r_resp_data SHALL equal the hold register (last read data is held indefinitely, including across intervening writes).
REQ-017 Back-to-back reads SHALL sustain one read per cycle, with each response 1 cycle after its request.
REQ-018 A read to an address written in the previous cycle SHALL return the new data; the block adds no bypass and none is needed because write and read fire in different cycles.
REQ-019 The block SHALL have no internal queuing: at most one macro access per cycle and no outstanding state beyond the 1-cycle response flag.

Reset
REQ-020 While reset=1, outputs SHALL be: state INIT, sweep counter 0, io_init_done 0, both readies 0, io_r_resp_valid 0, hold register 0 (so io_r_resp_data=0), sram_RW0_en 0.
REQ-021 Reset asserted mid-sweep SHALL restart the sweep at address 0 with a full 4096-cycle count.
REQ-022 Reset asserted in RUN SHALL discard any in-flight read response (io_r_resp_valid=0 in the next cycle) and re-enter INIT.
REQ-023 The first sweep write SHALL occur in the first cycle with reset=0.

Structure
REQ-024 A shared package SHALL hold DEPTH, ADDR_W, DATA_W, INIT_VAL and the state enum {INIT, RUN}.
REQ-025 One sub-module, sram_init_seq, SHALL contain the sweep counter and the done flag; it takes clock/reset and outputs the address and the active/done flags.
REQ-026 The macro-port mux, the response flag and the hold register SHALL live in the top module.

Verification
REQ-027 Reset release, no requests -> 4096 consecutive macro writes, addr 0..4095, wdata 0, readies 0 throughout; io_init_done=1 at cycle 4096; then en=0.
REQ-028 After init, write addr 0x123 data 7'h55, then read 0x123 next cycle -> resp_valid=1 one cycle later with data 7'h55; data stays 7'h55 for 10 idle cycles.
REQ-029 Same-cycle w_valid and r_valid -> r_ready=0, macro wmode=1 with write addr; read re-presented next cycle fires and returns the new data.
REQ-030 Reads to 0xFFF, 0x000, 0x800 on consecutive cycles after writing 7'h01, 7'h02, 7'h03 there -> three consecutive resp_valid cycles with 01, 02, 03.
REQ-031 Reset pulsed at sweep address 2000 -> sweep restarts at 0; done rises 4096 cycles after release.
REQ-032 Reset in the cycle after a read fire -> resp_valid=0 and resp_data=0.
